aquila_dbus_router: RTL
=======================

// Module: aquila_dbus_router
// PURPOSE
//  Registered data-bus router between the Aquila core data port and its targets: D-cache (cached DRAM),
//  NUM_DEV uncached device channels and the CLINT. It succeeds the combinational mem_sel decode at SoC top.
//  It adds per-transaction latching, a parametrised device count, a bus-fault response for unmapped
//  addresses and a device timeout.
// PARAMETERS
//  ADDR_WIDTH  32          address width
//  DATA_WIDTH  32          data width
//  NUM_DEV     2           number of uncached device channels (1..8)
//  DEV_TAGS    32'h0000_DC  NUM_DEV x 4-bit addr[31:28] tags; channel k = DEV_TAGS[4k+3:4k]
//  CLINT_TAG   4'hF        addr[31:28] tag of CLINT
//  TIMEOUT     1024        device cycles without ready before fault; 0 disables the timeout
// PORTS
//  clk            in   1              clock
//  rst            in   1              asynchronous active-high reset
//  p_strobe       in   1              core request (held until p_ready)
//  p_addr         in   ADDR_WIDTH     core address
//  p_rw           in   1              1=write
//  p_byte_enable  in   DATA_WIDTH/8   write byte lanes
//  p_wdata        in   DATA_WIDTH     write data
//  p_rdata        out  DATA_WIDTH     read data, registered
//  p_ready        out  1              1-cycle completion pulse
//  p_error        out  1              bus fault, valid with p_ready
//  c_strobe/c_rw  out  1/1            D-cache request pulse / write flag
//  c_addr/c_be/c_wdata  out  AW/DW/8/DW   latched request fields to D-cache
//  c_rdata/c_ready      in   DW/1         D-cache response
//  d_strobe       out  NUM_DEV        one-hot device request pulse
//  d_addr/d_rw/d_be/d_wdata  out  AW/1/DW/8/DW   shared latched device fields
//  d_rdata        in   NUM_DEV*DW     flattened device read data
//  d_ready        in   NUM_DEV        per-device done
//  clint_en/clint_we  out  1/1        CLINT access pulse
//  clint_addr     out  ADDR_WIDTH     {6'b0, addr[AW-5:2]}
//  clint_wdata    out  DW             CLINT write data
//  clint_rdata    in   DW             CLINT data, valid the cycle after clint_en
// BEHAVIOUR
//  Reset: every output is 0 and the FSM is in IDLE. Reset mid-transaction aborts it silently.
//  Decode of addr[31:28]:
//   - 4'h8..4'hB -> CACHE
//   - match DEV_TAGS[k] -> DEV k (lowest k wins)
//   - CLINT_TAG -> CLINT
//   - anything else -> FAULT
//  FSM states: IDLE, CACHE, DEV, CLINT, FAULT, DONE.
//  IDLE:
//   - On p_strobe, latch addr/rw/be/wdata/target.
//   - Pulse the target strobe for exactly 1 cycle, in the cycle after p_strobe is sampled.
//   - Go to the target state.
//  CACHE: wait for c_ready. Capture c_rdata into p_rdata, go to DONE.
//  DEV:
//   - Wait for d_ready[k] of the latched k. Ready bits of other channels are ignored.
//   - Capture d_rdata slice k, go to DONE.
//   - The timeout counter starts at 0 on entry and increments every cycle.
//   - If it reaches TIMEOUT without ready: p_rdata=0, set err flag, go to DONE.
//   - If ready and timeout coincide, ready wins and there is no error.
//  CLINT: clint_en is asserted for 1 cycle. p_rdata <= clint_rdata on the next cycle, go to DONE.
//  FAULT: p_rdata=0, err flag=1, go to DONE. No downstream strobe is ever issued.
//  DONE:
//   - p_ready=1 for 1 cycle and p_error=err.
//   - Return to IDLE. p_strobe is not sampled in DONE.
//  Request back-to-back rule: a new request is sampled in IDLE only, so at most 1 outstanding transaction.
//  Latency (p_strobe to p_ready) = target latency + 2 cycles. CLINT = 3 cycles, FAULT = 2 cycles.
//  Strobe width: c_strobe, d_strobe and clint_en are 1-cycle pulses. Downstream request fields are held
//  stable from the strobe until p_ready.
//  Writes: p_rdata is undefined-free and holds 0. Completion is still reported with p_ready.
//  Stray readies (c_ready or d_ready outside the matching state) are ignored.
// STRUCTURE
//  Shared header aquila_dbus_defs.vh holds:
//   - FSM state encodings (3-bit localparams)
//   - target codes
//   - the CACHE tag range
//   - the default CLINT_TAG
//  Sub-module dbus_timeout_ctr: clear/enable/expire counter, width $clog2(TIMEOUT+1).
//  Everything else stays inline.
// TESTING
//  1. Cache read at 0x8000_0010, c_ready 4 cycles after c_strobe with c_rdata=0xDEAD_BEEF
//     -> exactly one c_strobe, p_rdata=0xDEADBEEF, p_ready 1 cycle, p_error=0.
//  2. Device write to 0xD000_0004, be=4'b0011, data 0x1234_5678 (NUM_DEV=2, dev1=tag D)
//     -> d_strobe=2'b10, d_be=0011, d_wdata stable until d_ready[1], then p_ready.
//  3. Device read at 0xC000_0000 with TIMEOUT=16 and d_ready never set
//     -> p_ready+p_error exactly 16 cycles after entering DEV, p_rdata=0.
//  4. Read at 0x1000_0000 (unmapped) -> no strobes, p_ready+p_error 2 cycles after p_strobe.
//  5. CLINT read at 0xF000_0008 -> clint_en 1 cycle, clint_addr=0x2, p_rdata=clint_rdata, p_ready 3 cycles
//     after p_strobe.
//  6. Assert rst during DEV wait, then issue a cache read
//     -> all outputs 0 immediately, the later d_ready[0] is ignored, the cache read completes normally.

Source files
------------

// File: rtl/aquila_dbus_router_pkg.sv
// Shared definitions for the Aquila data-bus router: FSM states, target
// codes, the cached-DRAM tag range and the default CLINT tag.
package aquila_dbus_router_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CACHE = 3'd1,
    S_DEV   = 3'd2,
    S_CLINT = 3'd3,
    S_FAULT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TGT_CACHE = 2'd0,
    TGT_DEV   = 2'd1,
    TGT_CLINT = 2'd2,
    TGT_FAULT = 2'd3
  } tgt_t;

  localparam logic [3:0] CACHE_TAG_LO  = 4'h8;
  localparam logic [3:0] CACHE_TAG_HI  = 4'hB;
  localparam logic [3:0] CLINT_TAG_DEF = 4'hF;
  localparam int         MAX_DEV       = 8;

  // addr[31:28] values routed to the D-cache (cached DRAM window)
  function automatic logic is_cache_tag(input logic [3:0] tag);
    return (tag >= CACHE_TAG_LO) && (tag <= CACHE_TAG_HI);
  endfunction

endpackage

// File: rtl/aquila_dbus_router_timeout.sv
// Device-wait watchdog: cleared while idle, counts while enabled, flags
// expiry on the cycle the count would reach TIMEOUT. TIMEOUT=0 disables it.
module dbus_timeout_ctr #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // count cycles spent waiting; parks at LAST since the FSM leaves on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (clear)                  cnt <= '0;
    else if (enable && cnt != LAST)  cnt <= cnt + CW'(1);
  end

  // the edge ending this cycle is the one that takes the count to TIMEOUT
  assign expire = (TIMEOUT > 0) && enable && (cnt == LAST);

endmodule

// File: rtl/aquila_dbus_router.sv
// Registered data-bus router: latches one core request at a time, decodes
// addr[31:28] to D-cache / device k / CLINT / bus fault, issues a single
// strobe pulse and returns a one-cycle p_ready with registered data/error.
module aquila_dbus_router
  import aquila_dbus_router_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_DEV    = 2,
  parameter logic [31:0] DEV_TAGS   = 32'h0000_00DC,
  parameter logic [3:0]  CLINT_TAG  = CLINT_TAG_DEF,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  // core side
  input  logic                          p_strobe,
  input  logic [ADDR_WIDTH-1:0]         p_addr,
  input  logic                          p_rw,
  input  logic [DATA_WIDTH/8-1:0]       p_byte_enable,
  input  logic [DATA_WIDTH-1:0]         p_wdata,
  output logic [DATA_WIDTH-1:0]         p_rdata,
  output logic                          p_ready,
  output logic                          p_error,
  // D-cache
  output logic                          c_strobe,
  output logic                          c_rw,
  output logic [ADDR_WIDTH-1:0]         c_addr,
  output logic [DATA_WIDTH/8-1:0]       c_be,
  output logic [DATA_WIDTH-1:0]         c_wdata,
  input  logic [DATA_WIDTH-1:0]         c_rdata,
  input  logic                          c_ready,
  // uncached devices
  output logic [NUM_DEV-1:0]            d_strobe,
  output logic [ADDR_WIDTH-1:0]         d_addr,
  output logic                          d_rw,
  output logic [DATA_WIDTH/8-1:0]       d_be,
  output logic [DATA_WIDTH-1:0]         d_wdata,
  input  logic [NUM_DEV*DATA_WIDTH-1:0] d_rdata,
  input  logic [NUM_DEV-1:0]            d_ready,
  // CLINT
  output logic                          clint_en,
  output logic                          clint_we,
  output logic [ADDR_WIDTH-1:0]         clint_addr,
  output logic [DATA_WIDTH-1:0]         clint_wdata,
  input  logic [DATA_WIDTH-1:0]         clint_rdata
);

  state_t              state;
  tgt_t                tgt;
  logic [3:0]          tag;
  logic [2:0]          dec_idx;
  logic [2:0]          dev_idx;
  logic [NUM_DEV-1:0]  dec_onehot;
  logic                rw_q;
  logic                clint_phase;
  logic [DATA_WIDTH-1:0] dev_rdata;
  logic                dev_rdy;
  logic                tmo_clear;
  logic                tmo_en;
  logic                tmo_expire;

  assign tag = p_addr[ADDR_WIDTH-1 -: 4];

  // address decode: cache window first, then lowest matching device, then CLINT
  always_comb begin
    tgt     = TGT_FAULT;
    dec_idx = '0;
    if (is_cache_tag(tag)) begin
      tgt = TGT_CACHE;
    end else begin
      for (int k = NUM_DEV - 1; k >= 0; k--) begin
        if (DEV_TAGS[4*k +: 4] == tag) begin
          tgt     = TGT_DEV;
          dec_idx = 3'(k);
        end
      end
      if (tgt == TGT_FAULT && tag == CLINT_TAG) tgt = TGT_CLINT;
    end
  end

  // one-hot strobe pattern for the decoded device channel
  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < NUM_DEV; k++) dec_onehot[k] = (dec_idx == 3'(k));
  end

  // response select for the latched channel; other channels' readies are ignored
  always_comb begin
    dev_rdata = '0;
    dev_rdy   = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (dev_idx == 3'(k)) begin
        dev_rdata = d_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        dev_rdy   = d_ready[k];
      end
    end
  end

  assign tmo_clear = (state == S_IDLE);
  assign tmo_en    = (state == S_DEV);

  dbus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  // transaction FSM; every output is a register, strobes default low each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rw_q        <= 1'b0;
      dev_idx     <= '0;
      clint_phase <= 1'b0;
      p_rdata     <= '0;
      p_ready     <= 1'b0;
      p_error     <= 1'b0;
      c_strobe    <= 1'b0;
      c_rw        <= 1'b0;
      c_addr      <= '0;
      c_be        <= '0;
      c_wdata     <= '0;
      d_strobe    <= '0;
      d_addr      <= '0;
      d_rw        <= 1'b0;
      d_be        <= '0;
      d_wdata     <= '0;
      clint_en    <= 1'b0;
      clint_we    <= 1'b0;
      clint_addr  <= '0;
      clint_wdata <= '0;
    end else begin
      c_strobe <= 1'b0;
      d_strobe <= '0;
      clint_en <= 1'b0;
      clint_we <= 1'b0;
      p_ready  <= 1'b0;
      p_error  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p_strobe) begin
            rw_q        <= p_rw;
            dev_idx     <= dec_idx;
            clint_phase <= 1'b0;
            case (tgt)
              TGT_CACHE: begin
                c_strobe <= 1'b1;
                c_rw     <= p_rw;
                c_addr   <= p_addr;
                c_be     <= p_byte_enable;
                c_wdata  <= p_wdata;
                state    <= S_CACHE;
              end
              TGT_DEV: begin
                d_strobe <= dec_onehot;
                d_rw     <= p_rw;
                d_addr   <= p_addr;
                d_be     <= p_byte_enable;
                d_wdata  <= p_wdata;
                state    <= S_DEV;
              end
              TGT_CLINT: begin
                clint_en    <= 1'b1;
                clint_we    <= p_rw;
                clint_addr  <= {6'b0, p_addr[ADDR_WIDTH-5:2]};
                clint_wdata <= p_wdata;
                state       <= S_CLINT;
              end
              default: state <= S_FAULT;
            endcase
          end
        end
        S_CACHE: begin
          if (c_ready) begin
            p_rdata <= rw_q ? '0 : c_rdata;
            p_ready <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DEV: begin
          // ready takes priority over a coincident expiry
          if (dev_rdy) begin
            p_rdata <= rw_q ? '0 : dev_rdata;
            p_ready <= 1'b1;
            state   <= S_DONE;
          end else if (tmo_expire) begin
            p_rdata <= '0;
            p_ready <= 1'b1;
            p_error <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_CLINT: begin
          // CLINT data arrives the cycle after clint_en
          if (!clint_phase) begin
            clint_phase <= 1'b1;
          end else begin
            p_rdata <= rw_q ? '0 : clint_rdata;
            p_ready <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_FAULT: begin
          p_rdata <= '0;
          p_ready <= 1'b1;
          p_error <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
